// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer
//   Computes a signed 16x16 dot product over two vectors in data memory and
//   writes the 16-bit saturated result into the register file. The CPU is
//   stalled through `busy` for the whole operation.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        launch (taken only when idle) / cancel running op
//   base_a, base_w      vector base addresses (16-bit, address math wraps)
//   length, dst_reg     element count (0..255), destination register
//   mem_req/addr/gnt    read request handshake; mem_rdata is valid one
//   mem_rdata           cycle after a granted request
//   rf_we/waddr/wdata   register-file write port (active in WB only)
//   busy, done          operation in flight / one-cycle completion pulse
module dot_product_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] base_a,
    input  logic [15:0] base_w,
    input  logic [7:0]  length,
    input  logic [3:0]  dst_reg,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [15:0] mem_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, REQ_A, REQ_W, MAC, WB} state_t;

    typedef struct packed {
        logic [15:0] base_a;
        logic [15:0] base_w;
        logic [7:0]  len;
        logic [3:0]  dst;
    } params_t;

    state_t             state, state_nxt;
    params_t            prm;
    logic signed [31:0] acc;
    logic [7:0]         idx;
    logic signed [15:0] a_reg;
    logic               a_cap;     // previous cycle was a granted REQ_A
    logic signed [31:0] product;
    logic [32:0]        sum;
    logic [31:0]        acc_nxt;
    logic [15:0]        acc_sat16;

    // 16x16 signed product always fits in 32 bits.
    assign product = 32'(a_reg) * 32'($signed(mem_rdata));
    assign sum     = {acc[31], acc} + {product[31], product};

    // Accumulator saturation: a carry into bit 32 that disagrees with bit 31
    // means the 32-bit result overflowed; clamp toward the sign of the sum.
    always_comb begin
        acc_nxt = sum[31:0];
        if (sum[32] != sum[31])
            acc_nxt = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end

    always_comb begin
        acc_sat16 = acc[15:0];
        if (acc[31:15] != {17{acc[31]}})
            acc_sat16 = acc[31] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length == 8'd0) ? WB : REQ_A;
            REQ_A:   if (mem_gnt) state_nxt = REQ_W;
            REQ_W:   if (mem_gnt) state_nxt = MAC;
            MAC:     state_nxt = (idx == prm.len - 8'd1) ? WB : REQ_A;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Cancel beats every transition, including the write-back.
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = 16'd0;
        rf_we    = 1'b0;
        rf_waddr = 4'd0;
        rf_wdata = 16'd0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            REQ_A: begin
                mem_req  = 1'b1;
                mem_addr = prm.base_a + {8'd0, idx};
            end
            REQ_W: begin
                mem_req  = 1'b1;
                mem_addr = prm.base_w + {8'd0, idx};
            end
            WB: begin
                // An abort landing on the write-back cycle suppresses it.
                if (!abort) begin
                    rf_we    = 1'b1;
                    rf_waddr = prm.dst;
                    rf_wdata = acc_sat16;
                    done     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prm   <= '0;
            acc   <= '0;
            idx   <= '0;
            a_reg <= '0;
            a_cap <= 1'b0;
        end else begin
            // Read data only lands one cycle after the grant, so the capture
            // is keyed off a registered flag rather than the current state
            // (REQ_W may stall for several cycles with stale rdata).
            a_cap <= (state == REQ_A) && mem_gnt;
            if (a_cap) a_reg <= $signed(mem_rdata);
            if (state == IDLE && start) begin
                prm <= '{base_a: base_a, base_w: base_w, len: length, dst: dst_reg};
                acc <= '0;
                idx <= '0;
            end else if (state == MAC && !abort) begin
                acc <= $signed(acc_nxt);
                idx <= idx + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Testbench for dot_product_sequencer: transaction-level reference model
// (expected address stream + dot product computed with plain arithmetic),
// a memory responder with selectable grant behaviour, and directed plus
// randomized operations.
module tb_dot_product_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] base_a = '0;
    logic [15:0] base_w = '0;
    logic [7:0]  length = '0;
    logic [3:0]  dst_reg = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        done;

    dot_product_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_a(base_a), .base_w(base_w), .length(length), .dst_reg(dst_reg),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- memory + responder ----------------
    logic [15:0] mem [0:65535];
    int          gmode = 0;   // 0: grant tied high, 1: random, 2: grant after 3 low cycles
    int          gpct  = 60;
    logic        g_prev = 1'b0;
    logic [15:0] a_prev = '0;
    int          wcnt = 0;

    initial forever begin
        @(negedge clk);
        g_prev = mem_req && mem_gnt;
        a_prev = mem_addr;
        if (mem_req && !mem_gnt) wcnt++;
        else                     wcnt = 0;
    end

    initial forever begin
        @(posedge clk); #1;
        case (gmode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = ($urandom_range(0, 99) < gpct);
            default: mem_gnt = mem_req && (wcnt >= 3);
        endcase
        mem_rdata = g_prev ? mem[a_prev] : 16'($urandom);
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_dot(input logic [15:0] ba, input logic [15:0] bw, input int n);
        longint acc, hi, lo;
        logic [15:0] aa, ww;
        acc = 0;
        hi  = 64'sd2147483647;
        lo  = -64'sd2147483648;
        for (int i = 0; i < n; i++) begin
            aa  = ba + 16'(i);
            ww  = bw + 16'(i);
            acc = acc + longint'($signed(mem[aa])) * longint'($signed(mem[ww]));
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    // Model: an operation is a queue of request addresses (a0,w0,a1,w1,...);
    // after each W grant there is one non-requesting cycle, and after the
    // last one the write-back cycle.
    bit          m_act = 0, m_mac = 0, m_wb = 0;
    int          q[$];
    logic [15:0] m_val;
    logic [3:0]  m_dst;
    // observations of the current operation
    int          cyc = 0, busy_cnt = 0, req_cnt = 0, wb_cnt = 0, last_cyc = 0;
    logic [15:0] last_wdata = '0;
    logic [3:0]  last_waddr = '0;
    int          gq[$];

    task automatic chk_outs(input logic eb, input logic er, input logic [15:0] ea,
                            input logic ew, input logic [3:0] ewa, input logic [15:0] ewd);
        chk("busy", busy, eb);
        chk("mem_req", mem_req, er);
        chk("mem_addr", mem_addr, ea);
        chk("rf_we", rf_we, ew);
        chk("done", done, ew);
        chk("rf_waddr", rf_waddr, ewa);
        chk("rf_wdata", rf_wdata, ewd);
    endtask

    initial forever begin
        logic        er, ew;
        logic [15:0] ea;
        @(negedge clk);
        if (!rst_n) begin
            chk_outs(0, 0, 16'd0, 0, 4'd0, 16'd0);
            m_act = 0; m_mac = 0; m_wb = 0; q.delete();
        end else begin
            er = m_act && !m_mac && !m_wb;
            ea = (er && q.size() > 0) ? 16'(q[0]) : 16'd0;
            ew = m_act && m_wb && !abort;
            chk_outs(m_act, er, ea, ew, ew ? m_dst : 4'd0, ew ? m_val : 16'd0);
            if (m_act) begin
                cyc++;
                if (busy) busy_cnt++;
                if (mem_req) req_cnt++;
                if (mem_req && mem_gnt) gq.push_back(int'(mem_addr));
            end
            if (rf_we) begin
                wb_cnt++;
                last_wdata = rf_wdata;
                last_waddr = rf_waddr;
                last_cyc   = cyc;
            end
            if (!m_act) begin
                if (start) begin
                    m_act = 1; m_mac = 0; m_wb = (length == 8'd0);
                    m_dst = dst_reg;
                    m_val = ref_dot(base_a, base_w, int'(length));
                    q.delete();
                    for (int i = 0; i < int'(length); i++) begin
                        q.push_back(int'(16'(base_a + 16'(i))));
                        q.push_back(int'(16'(base_w + 16'(i))));
                    end
                    cyc = 0; busy_cnt = 0; req_cnt = 0; gq.delete();
                end
            end else if (abort) begin
                m_act = 0; m_mac = 0; m_wb = 0; q.delete();
            end else if (m_wb) begin
                m_act = 0; m_wb = 0;
            end else if (m_mac) begin
                m_mac = 0;
                if (q.size() == 0) m_wb = 1;
            end else if (mem_gnt) begin
                void'(q.pop_front());
                if (q.size() % 2 == 0) m_mac = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic launch(input logic [15:0] ba, input logic [15:0] bw,
                          input logic [7:0] n, input logic [3:0] d);
        base_a = ba; base_w = bw; length = n; dst_reg = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run until the DUT drops busy; optional random abort (per mille) and
    // random ignored start pulses while busy.
    task automatic run(input int budget, input int abort_pm, input int start_pct);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            abort = ($urandom_range(0, 999) < abort_pm);
            start = ($urandom_range(0, 99) < start_pct);
            if (start) begin
                base_a = 16'($urandom); base_w = 16'($urandom);
                length = 8'($urandom); dst_reg = 4'($urandom);
            end
            tick();
            n++;
        end
        abort = 1'b0;
        start = 1'b0;
        chk("run_timeout", (n < budget), 1);
    endtask

    function automatic logic [15:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int          wb_snap, n;
        logic [15:0] ba, bw;
        logic [7:0]  ln;

        // reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_rf_we", rf_we, 0);
        rst_n = 1'b1;
        tick();

        // basic: 3*5 + (-4)*2 = 7, WB in cycle 7
        gmode = 0;
        mem[100] = 16'd3; mem[101] = 16'hFFFC; mem[200] = 16'd5; mem[201] = 16'd2;
        wb_snap = wb_cnt;
        launch(16'd100, 16'd200, 8'd2, 4'd9);
        run(50, 0, 0);
        chk("basic_wdata", last_wdata, 16'd7);
        chk("basic_waddr", last_waddr, 4'd9);
        chk("basic_wb_cycle", last_cyc, 7);
        chk("basic_busy_cycles", busy_cnt, 7);
        chk("basic_wb_count", wb_cnt - wb_snap, 1);

        // zero length: immediate write-back of 0
        launch(16'd0, 16'd0, 8'd0, 4'd5);
        run(10, 0, 0);
        chk("len0_wdata", last_wdata, 16'd0);
        chk("len0_waddr", last_waddr, 4'd5);
        chk("len0_wb_cycle", last_cyc, 1);
        chk("len0_no_req", req_cnt, 0);

        // output saturation, positive and negative
        for (int i = 0; i < 4; i++) begin
            mem[16'(300 + i)] = 16'h7FFF; mem[16'(400 + i)] = 16'h7FFF;
        end
        launch(16'd300, 16'd400, 8'd4, 4'd1);
        run(50, 0, 0);
        chk("sat_pos", last_wdata, 16'h7FFF);
        for (int i = 0; i < 4; i++) mem[16'(300 + i)] = 16'h8000;
        launch(16'd300, 16'd400, 8'd4, 4'd1);
        run(50, 0, 0);
        chk("sat_neg", last_wdata, 16'h8000);

        // accumulator saturation then recovery: clamps at 2^31-1, ends at -1
        mem[500] = 16'h7FFF; mem[501] = 16'h7FFF; mem[502] = 16'h7FFF;
        mem[503] = 16'h8000; mem[504] = 16'h8000; mem[505] = 16'h8000;
        mem[600] = 16'h7FFF; mem[601] = 16'h7FFF; mem[602] = 16'h7FFF;
        mem[603] = 16'h7FFF; mem[604] = 16'h7FFF; mem[605] = 16'd2;
        launch(16'd500, 16'd600, 8'd6, 4'd2);
        run(50, 0, 0);
        chk("acc_sat", last_wdata, 16'hFFFF);

        // address wrap with stalled grants: 7*11 + (-3)*4 = 65
        gmode = 2;
        mem[16'hFFFF] = 16'd7; mem[16'h0000] = 16'hFFFD;
        mem[16'h1000] = 16'd11; mem[16'h1001] = 16'd4;
        launch(16'hFFFF, 16'h1000, 8'd2, 4'd3);
        run(100, 0, 0);
        chk("wrap_wdata", last_wdata, 16'd65);
        chk("wrap_ngnt", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("wrap_addr0", gq[0], 32'hFFFF);
            chk("wrap_addr1", gq[1], 32'h1000);
            chk("wrap_addr2", gq[2], 32'h0000);
            chk("wrap_addr3", gq[3], 32'h1001);
        end
        chk("wrap_req_cycles", req_cnt, 16);
        chk("wrap_wb_cycle", last_cyc, 19);

        // abort in REQ_W of element 1 (with grant), ignored mid-run start
        gmode = 0;
        mem[700] = 16'd1; mem[701] = 16'd2; mem[702] = 16'd3;
        mem[800] = 16'd4; mem[801] = 16'd5; mem[802] = 16'd6;
        wb_snap = wb_cnt;
        launch(16'd700, 16'd800, 8'd3, 4'd2);
        base_a = 16'd0; length = 8'd1; dst_reg = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr === 16'd801) && n < 20) begin tick(); n++; end
        chk("abort_reach", (n < 20), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_no_wb", wb_cnt - wb_snap, 0);
        launch(16'd700, 16'd800, 8'd3, 4'd2);
        run(50, 0, 0);
        chk("after_abort_wdata", last_wdata, 16'd32);

        // start and abort together in IDLE: start wins (2*3)
        mem[900] = 16'd2; mem[950] = 16'd3;
        abort = 1'b1;
        launch(16'd900, 16'd950, 8'd1, 4'd1);
        abort = 1'b0;
        run(20, 0, 0);
        chk("start_abort_idle", last_wdata, 16'd6);

        // abort on the write-back cycle suppresses the write
        wb_snap = wb_cnt;
        launch(16'd900, 16'd950, 8'd1, 4'd1);
        n = 0;
        while (rf_we !== 1'b1 && n < 20) begin tick(); n++; end
        chk("wb_reach", (n < 20), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wb_abort_idle", busy, 0);
        chk("wb_abort_no_wb", wb_cnt - wb_snap, 0);

        // reset during MAC (1*4 + 2*5 = 14 afterwards)
        wb_snap = wb_cnt;
        launch(16'd700, 16'd800, 8'd2, 4'd6);
        n = 0;
        while (!(busy === 1'b1 && mem_req === 1'b0 && rf_we === 1'b0) && n < 20) begin tick(); n++; end
        chk("mac_reach", (n < 20), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mac_busy", busy, 0);
        chk("rst_mac_req", mem_req, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_resume", busy, 0);
        chk("rst_no_wb", wb_cnt - wb_snap, 0);
        launch(16'd700, 16'd800, 8'd2, 4'd6);
        run(50, 0, 0);
        chk("after_rst_wdata", last_wdata, 16'd14);

        // maximum length
        gmode = 1; gpct = 80;
        ba = 16'($urandom); bw = 16'($urandom);
        for (int i = 0; i < 255; i++) begin
            mem[16'(ba + 16'(i))] = rnd_val();
            mem[16'(bw + 16'(i))] = rnd_val();
        end
        launch(ba, bw, 8'd255, 4'd7);
        run(3000, 0, 0);

        // randomized operations with random grants, aborts and stray starts
        for (int it = 0; it < 40; it++) begin
            gmode = $urandom_range(0, 1);
            gpct  = $urandom_range(30, 90);
            ba = 16'($urandom); bw = 16'($urandom);
            ln = 8'($urandom_range(0, 12));
            for (int i = 0; i < int'(ln); i++) begin
                mem[16'(ba + 16'(i))] = rnd_val();
                mem[16'(bw + 16'(i))] = rnd_val();
            end
            launch(ba, bw, ln, 4'($urandom));
            run(400, 15, 10);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
